mul_result_display: RTL and testbench
=====================================

Name: mul_result_display

Overview:
- Downstream consumer of the 2x2 sign-magnitude multiplier's 5-bit product (MSB = sign, low bits = magnitude).
- Captures each product with a valid/ready handshake.
- Converts the magnitude to BCD with a sequential double-dabble engine.
- Drives a 3-digit time-multiplexed seven-segment display: sign, tens, ones.

Parameters:
- MAG_W, 4, magnitude width of the product; legal range 1..6, so the maximum is 63 and always fits two BCD digits.
- SCAN_DIV, 1000, clock cycles each digit stays enabled; legal when >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- res_in  in  MAG_W+1  product; bit MAG_W = sign (1 = negative), bits MAG_W-1:0 = magnitude.
- res_valid  in  1  res_in is valid this cycle.
- res_ready  out  1  block accepts res_in this cycle.
- seg  out  7  segment drive {g,f,e,d,c,b,a}; active-high by default.
- an  out  3  one-hot digit enable: an[0] = ones, an[1] = tens, an[2] = sign; active-high by default.
- busy  out  1  conversion in progress.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; res_ready = 1; busy = 0.
  - Displayed value = +0: sign blank, tens blank, ones "0".
  - an = 3'b001; scan counter = 0.
  - seg shows the glyph of the enabled digit ("0" = 7'b0111111).
- FSM states:
  - IDLE: res_ready = 1. On res_valid & res_ready, latch sign and magnitude, load the shift register {8'b0, mag} and the iteration counter, then go to CONVERT.
  - CONVERT: res_ready = 0, busy = 1. Runs exactly MAG_W cycles. Each cycle: add 3 to any BCD nibble >= 5, then shift left 1. After the last iteration, commit {sign_disp, tens, ones} atomically to the display registers and go to SHOW.
  - SHOW: identical to IDLE for handshaking (res_ready = 1). A new accept goes to CONVERT. The old value stays displayed until the new commit.
- Latency: accept edge to new glyphs visible on the display registers = MAG_W+1 cycles.
- Display registers never show intermediate conversion values.
- Sign normalisation: sign digit shows "-" (7'b1000000) only when sign = 1 and magnitude != 0. Negative zero displays as +0.
- Leading-zero suppression: tens digit is blank when tens == 0. The ones digit is always shown.
- Scan:
  - A free-running counter counts 0..SCAN_DIV-1. On wrap, an rotates 001 -> 010 -> 100 -> 001.
  - seg is registered and updates in the same cycle as an. No cycle ever pairs a digit's enable with another digit's glyph.
  - Scanning runs independently of the FSM, including during CONVERT.
- res_valid asserted during CONVERT is ignored: no accept and no side effect. The upstream holds data until res_ready.
- Reset asserted mid-CONVERT aborts the conversion. The display returns to +0 and no partial commit occurs.
- Glyphs 0..9: 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111101, 0000111, 1111111, 1101111. Blank = 0000000.

Optional Feature:
- Macro: SEG_ACTIVE_LOW_EN.
- Defined: seg and an are driven inverted, for common-anode boards. Reset values invert accordingly (blank = 7'b1111111, an reset = 3'b110).
- Undefined: active-high as specified above. FSM and timing are identical in both builds.

Decomposition:
- Shared package holds:
  - state enum {IDLE, CONVERT, SHOW}.
  - glyph constants GLYPH_0..GLYPH_9, GLYPH_MINUS, GLYPH_BLANK.
  - digit index constants DIG_ONES, DIG_TENS, DIG_SIGN.
- One sub-module, seg7_decode: combinational 4-bit BCD plus blank/minus select -> 7-bit glyph, reusable by other calculator result stages.
- Double-dabble, FSM and scan logic stay in the top module.

Test Plan:
- Reset release with SCAN_DIV=4 -> an = 001, seg = 0111111. After 4 cycles an = 010, seg = 0000000. After 8 cycles an = 100, seg = 0000000.
- Accept res_in = 5'b0_1001 (+9) -> res_ready low for exactly 4 cycles; busy high for 4 cycles. Then ones = 1101111, tens blank, sign blank.
- Accept 5'b1_0110 (-6) -> sign digit 1000000, ones 1111101, tens blank.
- Accept 5'b1_0000 (negative zero) -> sign blank, ones 0111111.
- Accept 5'b0_1111 (15) -> tens 0000110, ones 1101101.
- Hold res_valid = 1 with a new value during CONVERT -> no accept until SHOW. Second value is taken the first cycle res_ready = 1. Displayed value changes only at each commit.
- Reset pulsed on cycle 2 of CONVERT -> display returns to +0, state IDLE, res_ready = 1 immediately.

Source files
------------

// File: rtl/mul_result_display_pkg.sv
`default_nettype none
// ==========================================================================
// mul_result_display_pkg : FSM states, seven-segment glyphs, digit indices
// Revision: 1.0
// ==========================================================================
package mul_result_display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SHOW    = 2'd2
  } state_t;

  // Segment order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] GLYPH_0     = 7'b0111111;
  localparam logic [6:0] GLYPH_1     = 7'b0000110;
  localparam logic [6:0] GLYPH_2     = 7'b1011011;
  localparam logic [6:0] GLYPH_3     = 7'b1001111;
  localparam logic [6:0] GLYPH_4     = 7'b1100110;
  localparam logic [6:0] GLYPH_5     = 7'b1101101;
  localparam logic [6:0] GLYPH_6     = 7'b1111101;
  localparam logic [6:0] GLYPH_7     = 7'b0000111;
  localparam logic [6:0] GLYPH_8     = 7'b1111111;
  localparam logic [6:0] GLYPH_9     = 7'b1101111;
  localparam logic [6:0] GLYPH_MINUS = 7'b1000000;
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

  localparam int DIG_ONES = 0;
  localparam int DIG_TENS = 1;
  localparam int DIG_SIGN = 2;

  function automatic logic [6:0] bcd_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = GLYPH_0;
      4'd1:    g = GLYPH_1;
      4'd2:    g = GLYPH_2;
      4'd3:    g = GLYPH_3;
      4'd4:    g = GLYPH_4;
      4'd5:    g = GLYPH_5;
      4'd6:    g = GLYPH_6;
      4'd7:    g = GLYPH_7;
      4'd8:    g = GLYPH_8;
      4'd9:    g = GLYPH_9;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_result_display_seg7_decode.sv
`default_nettype none
// ==========================================================================
// seg7_decode : BCD digit with minus/blank override -> active-high glyph
// Revision: 1.0
// ==========================================================================
module seg7_decode
  import mul_result_display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       minus,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = bcd_glyph(bcd);
    if (minus)
      glyph = GLYPH_MINUS;
    else if (blank)
      glyph = GLYPH_BLANK;
  end

endmodule
`default_nettype wire

// File: rtl/mul_result_display.sv
`default_nettype none
// ==========================================================================
// mul_result_display : product capture, double-dabble BCD, 3-digit 7-seg scan
// Option: SEG_ACTIVE_LOW_EN inverts seg/an for common-anode boards.
// Revision: 1.0
// ==========================================================================
module mul_result_display
  import mul_result_display_pkg::*;
#(
  parameter int MAG_W    = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [MAG_W:0]   res_in,
  input  logic             res_valid,
  output logic             res_ready,
  output logic [6:0]       seg,
  output logic [2:0]       an,
  output logic             busy
);

  localparam int SR_W = MAG_W + 8;
  localparam int IT_W = $clog2(MAG_W + 1);
  localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t            state, state_nxt;
  logic              accept, last_iter;
  logic [SR_W-1:0]   sr, sr_adj, sr_shift;
  logic [IT_W-1:0]   iter;
  logic              neg_lat;

  logic              disp_neg;
  logic [3:0]        disp_tens, disp_ones;

  logic [SC_W-1:0]   scan_cnt;
  logic              scan_wrap;
  logic [2:0]        an_r, an_nxt;
  logic [6:0]        seg_r, glyph;
  logic [3:0]        dec_bcd;
  logic              dec_blank, dec_minus;

  assign accept    = res_valid & res_ready;
  assign last_iter = (state == CONVERT) && (iter == IT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, SHOW: if (accept)    state_nxt = CONVERT;
      CONVERT:    if (last_iter) state_nxt = SHOW;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    res_ready = 1'b1;
    busy      = 1'b0;
    if (state == CONVERT) begin
      res_ready = 1'b0;
      busy      = 1'b1;
    end
  end

  // One double-dabble step: correct each BCD nibble, then shift in the next bit
  always_comb begin
    sr_adj = sr;
    if (sr[MAG_W+3 -: 4] >= 4'd5)
      sr_adj[MAG_W+3 -: 4] = sr[MAG_W+3 -: 4] + 4'd3;
    if (sr[SR_W-1 -: 4] >= 4'd5)
      sr_adj[SR_W-1 -: 4] = sr[SR_W-1 -: 4] + 4'd3;
    sr_shift = {sr_adj[SR_W-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr        <= '0;
      iter      <= '0;
      neg_lat   <= 1'b0;
      disp_neg  <= 1'b0;
      disp_tens <= 4'd0;
      disp_ones <= 4'd0;
    end else if (accept) begin
      sr      <= {8'b0, res_in[MAG_W-1:0]};
      iter    <= IT_W'(MAG_W);
      neg_lat <= res_in[MAG_W] & (|res_in[MAG_W-1:0]);
    end else if (state == CONVERT) begin
      sr   <= sr_shift;
      iter <= iter - 1'b1;
      if (last_iter) begin
        disp_neg  <= neg_lat;
        disp_tens <= sr_shift[MAG_W+7 -: 4];
        disp_ones <= sr_shift[MAG_W+3 -: 4];
      end
    end
  end

  assign scan_wrap = (scan_cnt == SC_W'(SCAN_DIV - 1));
  assign an_nxt    = scan_wrap ? {an_r[1:0], an_r[2]} : an_r;

  // Glyph is chosen for the digit enabled after this edge, so seg and an move together
  always_comb begin
    dec_bcd   = disp_ones;
    dec_blank = 1'b0;
    dec_minus = 1'b0;
    if (an_nxt[DIG_TENS]) begin
      dec_bcd   = disp_tens;
      dec_blank = (disp_tens == 4'd0);
    end else if (an_nxt[DIG_SIGN]) begin
      dec_bcd   = 4'd0;
      dec_blank = ~disp_neg;
      dec_minus = disp_neg;
    end
  end

  seg7_decode u_dec (
    .bcd   (dec_bcd),
    .blank (dec_blank),
    .minus (dec_minus),
    .glyph (glyph)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      an_r     <= 3'b001;
      seg_r    <= GLYPH_0;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      an_r     <= an_nxt;
      seg_r    <= glyph;
    end
  end

`ifdef SEG_ACTIVE_LOW_EN
  assign seg = ~seg_r;
  assign an  = ~an_r;
`else
  assign seg = seg_r;
  assign an  = an_r;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_result_display.sv
`default_nettype none
// ==========================================================================
// tb_mul_result_display : directed self-checking bench, MAG_W=4, SCAN_DIV=4
// Revision: 1.0
// ==========================================================================
module tb_mul_result_display;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] res_in;
  logic       res_valid;
  logic       res_ready;
  logic [6:0] seg;
  logic [2:0] an;
  logic       busy;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] G_BLANK = 7'b0000000;
  localparam logic [6:0] G_MINUS = 7'b1000000;

  mul_result_display #(.MAG_W(4), .SCAN_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .res_in    (res_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .seg       (seg),
    .an        (an),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] digit_glyph(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  // Expected glyph for whichever digit the given enable selects
  function automatic logic [6:0] exp_for_an(input logic [2:0] a, input logic neg,
                                            input int tens, input int ones);
    case (a)
      3'b001:  return digit_glyph(ones);
      3'b010:  return (tens == 0) ? G_BLANK : digit_glyph(tens);
      3'b100:  return neg ? G_MINUS : G_BLANK;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  task automatic get_digit(input int dig, output logic [6:0] g);
    logic [2:0] want;
    int n;
    want = 3'b001 << dig;
    n = 0;
    g = 7'bxxxxxxx;
    while (an !== want && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (an === want) begin
      g = seg;
    end else begin
      checks++;
      errors++;
      $display("FAIL digit_wait: an=%b never reached %b", an, want);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    checks++; if (an !== 3'b001)        begin errors++; $display("FAIL reset_an: got %b want 001", an); end
    checks++; if (seg !== 7'b0111111)   begin errors++; $display("FAIL reset_seg: got %b want 0111111", seg); end
    checks++; if (res_ready !== 1'b1)   begin errors++; $display("FAIL reset_ready: got %b want 1", res_ready); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    repeat (4) @(negedge clk);
    checks++; if (an !== 3'b010)        begin errors++; $display("FAIL scan_tens_an: got %b want 010", an); end
    checks++; if (seg !== G_BLANK)      begin errors++; $display("FAIL scan_tens_seg: got %b want 0000000", seg); end
    repeat (4) @(negedge clk);
    checks++; if (an !== 3'b100)        begin errors++; $display("FAIL scan_sign_an: got %b want 100", an); end
    checks++; if (seg !== G_BLANK)      begin errors++; $display("FAIL scan_sign_seg: got %b want 0000000", seg); end
  endtask

  task automatic test_accept(input string name, input logic [4:0] value,
                             input logic [6:0] e_sign, input logic [6:0] e_tens,
                             input logic [6:0] e_ones);
    int cnt;
    logic [6:0] g;
    checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_before: got %b want 1", name, res_ready); end
    res_valid = 1'b1;
    res_in    = value;
    @(negedge clk);
    res_valid = 1'b0;
    cnt = 0;
    while (res_ready === 1'b0 && cnt < 20) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy: got %b want 1", name, busy); end
      cnt++;
      @(negedge clk);
    end
    checks++; if (cnt != 4)      begin errors++; $display("FAIL %s_ready_low_cycles: got %0d want 4", name, cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_after: got %b want 0", name, busy); end
    @(negedge clk);
    get_digit(2, g);
    checks++; if (g !== e_sign) begin errors++; $display("FAIL %s_sign: got %b want %b", name, g, e_sign); end
    get_digit(1, g);
    checks++; if (g !== e_tens) begin errors++; $display("FAIL %s_tens: got %b want %b", name, g, e_tens); end
    get_digit(0, g);
    checks++; if (g !== e_ones) begin errors++; $display("FAIL %s_ones: got %b want %b", name, g, e_ones); end
  endtask

  // Display holds +15; A = +12 held valid, then B = -3 held valid through CONVERT
  task automatic test_back_to_back;
    logic [6:0] g;
    res_valid = 1'b1;
    res_in    = 5'b0_1100;
    @(negedge clk);
    res_in = 5'b1_0011;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL b2b_a_ready n%0d: got %b want 0", k, res_ready); end
      checks++; if (seg !== exp_for_an(an, 1'b0, 1, 5)) begin errors++; $display("FAIL b2b_old_seg n%0d: got %b want %b", k, seg, exp_for_an(an, 1'b0, 1, 5)); end
      @(negedge clk);
    end
    checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL b2b_show_ready: got %b want 1", res_ready); end
    checks++; if (seg !== exp_for_an(an, 1'b0, 1, 5)) begin errors++; $display("FAIL b2b_old_seg_show: got %b want %b", seg, exp_for_an(an, 1'b0, 1, 5)); end
    @(negedge clk);
    res_valid = 1'b0;
    for (int k = 6; k <= 9; k++) begin
      checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL b2b_b_ready n%0d: got %b want 0", k, res_ready); end
      checks++; if (seg !== exp_for_an(an, 1'b0, 1, 2)) begin errors++; $display("FAIL b2b_a_seg n%0d: got %b want %b", k, seg, exp_for_an(an, 1'b0, 1, 2)); end
      @(negedge clk);
    end
    checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL b2b_final_ready: got %b want 1", res_ready); end
    checks++; if (seg !== exp_for_an(an, 1'b0, 1, 2)) begin errors++; $display("FAIL b2b_a_seg_show: got %b want %b", seg, exp_for_an(an, 1'b0, 1, 2)); end
    @(negedge clk);
    checks++; if (seg !== exp_for_an(an, 1'b1, 0, 3)) begin errors++; $display("FAIL b2b_b_seg: got %b want %b", seg, exp_for_an(an, 1'b1, 0, 3)); end
    get_digit(2, g);
    checks++; if (g !== G_MINUS)    begin errors++; $display("FAIL b2b_b_sign: got %b want 1000000", g); end
    get_digit(0, g);
    checks++; if (g !== 7'b1001111) begin errors++; $display("FAIL b2b_b_ones: got %b want 1001111", g); end
  endtask

  task automatic test_reset_mid_convert;
    logic [6:0] g;
    res_valid = 1'b1;
    res_in    = 5'b0_1111;
    @(negedge clk);
    res_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (res_ready !== 1'b1)  begin errors++; $display("FAIL rstmid_ready: got %b want 1", res_ready); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (an !== 3'b001)       begin errors++; $display("FAIL rstmid_an: got %b want 001", an); end
    checks++; if (seg !== 7'b0111111)  begin errors++; $display("FAIL rstmid_seg: got %b want 0111111", seg); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    get_digit(2, g);
    checks++; if (g !== G_BLANK)    begin errors++; $display("FAIL rstmid_sign: got %b want 0000000", g); end
    get_digit(1, g);
    checks++; if (g !== G_BLANK)    begin errors++; $display("FAIL rstmid_tens: got %b want 0000000", g); end
    get_digit(0, g);
    checks++; if (g !== 7'b0111111) begin errors++; $display("FAIL rstmid_ones: got %b want 0111111", g); end
    repeat (8) @(negedge clk);
    get_digit(0, g);
    checks++; if (g !== 7'b0111111) begin errors++; $display("FAIL rstmid_no_late_commit: got %b want 0111111", g); end
    checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL rstmid_idle_ready: got %b want 1", res_ready); end
  endtask

  initial begin
    rst_n     = 1'b0;
    res_valid = 1'b0;
    res_in    = 5'b0;
    repeat (2) @(negedge clk);
    test_reset;
    test_accept("pos9",  5'b0_1001, G_BLANK, G_BLANK,    7'b1101111);
    test_accept("neg6",  5'b1_0110, G_MINUS, G_BLANK,    7'b1111101);
    test_accept("negz",  5'b1_0000, G_BLANK, G_BLANK,    7'b0111111);
    test_accept("pos15", 5'b0_1111, G_BLANK, 7'b0000110, 7'b1101101);
    test_back_to_back;
    test_reset_mid_convert;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
